// File: rtl/atom_mem_arbiter_if.sv
// Signal bundle for atom_mem_arbiter. It carries the CPU bus, the HPS download stream and the memory port.
// slave  : the arbiter's view. It receives CPU and download requests, drives the memory port and returns status.
// master : the surrounding core's view. It drives the requests and the memory read data.
interface atom_mem_arbiter_if;
  // CPU bus
  logic        cpu_en;
  logic [17:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  // HPS download stream
  logic        dl_active;
  logic        dl_wr;
  logic [11:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        dl_done;
  logic        dl_overflow;
  logic        cpu_hold;
  // shared single-port memory
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  modport slave (
    input  cpu_en, cpu_addr, cpu_we, cpu_din,
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  mem_dout,
    output cpu_dout, dl_wait, dl_done, dl_overflow, cpu_hold,
    output mem_addr, mem_we, mem_din
  );

  modport master (
    output cpu_en, cpu_addr, cpu_we, cpu_din,
    output dl_active, dl_wr, dl_addr, dl_data,
    output mem_dout,
    input  cpu_dout, dl_wait, dl_done, dl_overflow, cpu_hold,
    input  mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/atom_mem_arbiter.sv
// Purpose : arbitrates the single-port Atom memory between the CPU (always first) and the buffered HPS download.
// Latency : grant is combinational; CPU read data lands in cpu_dout two cycles after cpu_en; a queued byte writes >=1 cycle after dl_wr.
// Backpressure: registered dl_wait asserts when the FIFO will hold >= FIFO_DEPTH-1 bytes; a byte arriving while full is dropped (sticky dl_overflow).
// Ports: clk_sys/reset_n (async active-low) plus bus (atom_mem_arbiter_if.slave):
//   cpu_* request/read data, dl_* download stream and status, cpu_hold, mem_* memory port.
module atom_mem_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [17:0] DL_BASE    = 18'h17000,
  parameter logic [63:0] WP_MASK    = 64'h0000_F4C0_007F_F000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  atom_mem_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } dl_ent_t;

  dl_ent_t          fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dl_wait_q, dl_wait_d;
  logic             ovf_q, ovf_d;
  logic             act_q;
  logic [1:0]       state_q, state_d;
  logic             rd_pend_q;
  logic [7:0]       cpu_dout_q;
  logic [17:0]      last_addr_q;

  logic             full, pop, push, drop, rise;
  dl_ent_t          head;
  logic [17:0]      mem_addr_c;
  logic             mem_we_c;
  logic [7:0]       mem_din_c;

  // The pop decision looks only at the registered count. A byte pushed into an empty FIFO
  // therefore cannot be written in the same cycle.
  assign full = (cnt_q == DEPTH_C);
  assign pop  = ~bus.cpu_en & (cnt_q != '0);
  assign push = bus.dl_wr & (~full | pop);
  assign drop = bus.dl_wr & full & ~pop;
  assign rise = bus.dl_active & ~act_q;
  assign head = fifo_q[rd_ptr_q];

  // Memory port mux. CPU writes are filtered per 4 KB page. Loader writes bypass protection.
  always_comb begin
    mem_addr_c = last_addr_q;
    mem_we_c   = 1'b0;
    mem_din_c  = 8'h00;
    if (bus.cpu_en) begin
      mem_addr_c = bus.cpu_addr;
      mem_din_c  = bus.cpu_din;
      mem_we_c   = bus.cpu_we & ~WP_MASK[bus.cpu_addr[17:12]];
    end else if (pop) begin
      mem_addr_c = DL_BASE + {6'b0, head.addr};
      mem_din_c  = head.data;
      mem_we_c   = 1'b1;
    end
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_din     = mem_din_c;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.dl_wait     = dl_wait_q;
  assign bus.dl_overflow = ovf_q;
  assign bus.cpu_hold    = (state_q == ST_LOADING) | (state_q == ST_DRAIN);
  assign bus.dl_done     = (state_q == ST_DONE);

  // FIFO bookkeeping
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    dl_wait_d = (cnt_d >= WAIT_C);
    // A drop in the same cycle as a new download start still leaves the flag set.
    ovf_d = ovf_q;
    if (rise) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  // Download sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rise) state_d = ST_LOADING;
      ST_LOADING: if (!bus.dl_active) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (rise)                        state_d = ST_LOADING;
        else if ((cnt_q == '0) && !pop)  state_d = ST_DONE;
      end
      ST_DONE:    state_d = rise ? ST_LOADING : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      dl_wait_q   <= 1'b0;
      ovf_q       <= 1'b0;
      act_q       <= 1'b0;
      state_q     <= ST_IDLE;
      rd_pend_q   <= 1'b0;
      cpu_dout_q  <= 8'h00;
      last_addr_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      dl_wait_q <= dl_wait_d;
      ovf_q     <= ovf_d;
      act_q     <= bus.dl_active;
      state_q   <= state_d;
      // The memory returns data one cycle after the address. Capture it at the end of that cycle.
      rd_pend_q <= bus.cpu_en & ~bus.cpu_we;
      if (rd_pend_q)  cpu_dout_q  <= bus.mem_dout;
      if (bus.cpu_en) last_addr_q <= bus.cpu_addr;
    end
  end

  // Entry storage needs no reset because the pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: bus.dl_addr, data: bus.dl_data};
  end

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Directed bench for atom_mem_arbiter with a behavioural single-port memory.
// Expected memory writes are queued when the stimulus is driven. A monitor checks each observed write against that queue.
module tb_atom_mem_arbiter;

  logic clk_sys;
  logic reset_n;
  int   checks;
  int   errors;

  atom_mem_arbiter_if bus ();

  atom_mem_arbiter #(
    .FIFO_DEPTH (4),
    .DL_BASE    (18'h17000),
    .WP_MASK    (64'h0000_F4C0_007F_F000)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // The memory registers the address, so read data follows one cycle later.
  logic [7:0] mem [262144];
  always @(posedge clk_sys) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  typedef struct packed {
    logic [17:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [17:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  always @(negedge clk_sys) begin
    if (reset_n && bus.mem_we) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%05h data=%02h expected no write",
               bus.mem_addr, bus.mem_din);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.a));
        chk("wr_data", 32'(bus.mem_din), 32'(mon_e.d));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_sys);
  endtask

  task automatic drive_cpu(input logic en, input logic we, input logic [17:0] a, input logic [7:0] d);
    bus.cpu_en   = en;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
  endtask

  task automatic drive_dl(input logic act, input logic wr, input logic [11:0] a, input logic [7:0] d);
    bus.dl_active = act;
    bus.dl_wr     = wr;
    bus.dl_addr   = a;
    bus.dl_data   = d;
  endtask

  initial begin
    logic found;
    checks = 0;
    errors = 0;
    mem[18'h0C123] = 8'hA5;
    reset_n = 1'b0;
    drive_cpu(1'b0, 1'b0, 18'h0, 8'h0);
    drive_dl(1'b0, 1'b0, 12'h0, 8'h0);

    // Reset state
    mid();
    chk("rst_cpu_dout", 32'(bus.cpu_dout), 0);
    chk("rst_dl_wait", 32'(bus.dl_wait), 0);
    chk("rst_dl_done", 32'(bus.dl_done), 0);
    chk("rst_dl_overflow", 32'(bus.dl_overflow), 0);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_din", 32'(bus.mem_din), 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // CPU read: data visible two cycles after cpu_en, then held
    drive_cpu(1'b1, 1'b0, 18'h0C123, 8'h00);
    mid();
    chk("rd_mem_we", 32'(bus.mem_we), 0);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'h0C123);
    cyc();
    drive_cpu(1'b0, 1'b0, 18'h0, 8'h00);
    mid();
    chk("rd_not_early", 32'(bus.cpu_dout), 0);
    cyc(); mid();
    chk("rd_data", 32'(bus.cpu_dout), 32'hA5);
    for (int i = 0; i < 10; i++) begin
      cyc(); mid();
      chk("rd_hold", 32'(bus.cpu_dout), 32'hA5);
    end

    // Write protection
    cyc();
    drive_cpu(1'b1, 1'b1, 18'h0F000, 8'h3C);
    mid();
    chk("wp_0F000_we", 32'(bus.mem_we), 0);
    cyc();
    drive_cpu(1'b1, 1'b1, 18'h2C000, 8'h3C);
    mid();
    chk("wp_2C000_we", 32'(bus.mem_we), 0);
    cyc();
    push_wr(18'h02000, 8'h3C);
    drive_cpu(1'b1, 1'b1, 18'h02000, 8'h3C);
    mid();
    chk("wp_02000_we", 32'(bus.mem_we), 1);
    chk("wp_02000_din", 32'(bus.mem_din), 32'h3C);
    cyc();
    push_wr(18'h17010, 8'h3C);
    drive_cpu(1'b1, 1'b1, 18'h17010, 8'h3C);
    mid();
    chk("wp_17010_we", 32'(bus.mem_we), 1);
    cyc();
    drive_cpu(1'b0, 1'b0, 18'h0, 8'h00);
    cyc(); mid();
    chk("wr_keeps_dout", 32'(bus.cpu_dout), 32'hA5);

    // Download under continuous CPU contention (protected CPU writes, so nothing lands)
    cyc();
    drive_cpu(1'b1, 1'b1, 18'h0F000, 8'h99);
    drive_dl(1'b1, 1'b0, 12'h0, 8'h0);
    mid();
    chk("hold_before_rise", 32'(bus.cpu_hold), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      push_wr(18'h17000 + 18'(i), 8'h10 + 8'(i));
      drive_dl(1'b1, 1'b1, 12'(i), 8'h10 + 8'(i));
      mid();
      if (i == 0) chk("hold_after_rise", 32'(bus.cpu_hold), 1);
      chk("contend_mem_we", 32'(bus.mem_we), 0);
      chk("dl_wait_level", 32'(bus.dl_wait), (i >= 3) ? 1 : 0);
    end
    // Overflow: one more byte into a full FIFO while the CPU still owns memory
    cyc();
    drive_dl(1'b1, 1'b1, 12'h004, 8'hEE);
    mid();
    chk("ovf_before", 32'(bus.dl_overflow), 0);
    cyc();
    drive_dl(1'b1, 1'b0, 12'h0, 8'h0);
    mid();
    chk("ovf_set", 32'(bus.dl_overflow), 1);
    chk("full_dl_wait", 32'(bus.dl_wait), 1);
    cyc();
    drive_cpu(1'b0, 1'b0, 18'h0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("drain_we", 32'(bus.mem_we), 1);
      chk("drain_addr", 32'(bus.mem_addr), 32'h17000 + i);
      cyc();
    end
    mid();
    chk("dropped_not_written", 32'(bus.mem_we), 0);
    chk("load_keeps_dout", 32'(bus.cpu_dout), 32'hA5);

    // dl_active falls then rises again: overflow clears, hold stays up
    cyc();
    drive_dl(1'b0, 1'b0, 12'h0, 8'h0);
    cyc();
    drive_dl(1'b1, 1'b0, 12'h0, 8'h0);
    mid();
    chk("ovf_still_set", 32'(bus.dl_overflow), 1);
    chk("hold_in_drain", 32'(bus.cpu_hold), 1);
    cyc(); mid();
    chk("ovf_cleared", 32'(bus.dl_overflow), 0);
    chk("no_done_on_rerise", 32'(bus.dl_done), 0);

    // Completion with two bytes queued
    drive_cpu(1'b1, 1'b0, 18'h0C123, 8'h00);
    cyc();
    push_wr(18'h17020, 8'h55);
    drive_dl(1'b1, 1'b1, 12'h020, 8'h55);
    cyc();
    push_wr(18'h17021, 8'h66);
    drive_dl(1'b1, 1'b1, 12'h021, 8'h66);
    cyc();
    drive_cpu(1'b0, 1'b0, 18'h0, 8'h00);
    drive_dl(1'b0, 1'b0, 12'h0, 8'h0);
    mid();
    chk("cmp_wr0_addr", 32'(bus.mem_addr), 32'h17020);
    chk("cmp_hold0", 32'(bus.cpu_hold), 1);
    cyc(); mid();
    chk("cmp_wr1_addr", 32'(bus.mem_addr), 32'h17021);
    chk("cmp_done_early", 32'(bus.dl_done), 0);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cyc(); mid();
      if (bus.dl_done) begin
        found = 1'b1;
        chk("hold_falls_with_done", 32'(bus.cpu_hold), 0);
      end
    end
    chk("done_seen", 32'(found), 1);
    cyc(); mid();
    chk("done_one_cycle", 32'(bus.dl_done), 0);

    // Byte arriving with no download active is still written, without a state change
    cyc();
    push_wr(18'h170FF, 8'h77);
    drive_dl(1'b0, 1'b1, 12'h0FF, 8'h77);
    cyc();
    drive_dl(1'b0, 1'b0, 12'h0, 8'h0);
    mid();
    chk("idle_wr_we", 32'(bus.mem_we), 1);
    chk("idle_wr_hold", 32'(bus.cpu_hold), 0);
    cyc(); mid();
    chk("idle_wr_no_done", 32'(bus.dl_done), 0);

    // Async reset while draining three queued bytes
    cyc();
    drive_cpu(1'b1, 1'b0, 18'h0C123, 8'h00);
    drive_dl(1'b1, 1'b0, 12'h0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive_dl(1'b1, 1'b1, 12'h040 + 12'(i), 8'hA0 + 8'(i));
    end
    cyc();
    drive_dl(1'b0, 1'b0, 12'h0, 8'h0);
    cyc();
    mid();
    chk("pre_rst_hold", 32'(bus.cpu_hold), 1);
    #2;
    drive_cpu(1'b0, 1'b0, 18'h0, 8'h00);
    reset_n = 1'b0;
    #1;
    chk("arst_cpu_dout", 32'(bus.cpu_dout), 0);
    chk("arst_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("arst_mem_we", 32'(bus.mem_we), 0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 0);
    chk("arst_mem_din", 32'(bus.mem_din), 0);
    chk("arst_dl_wait", 32'(bus.dl_wait), 0);
    chk("arst_dl_done", 32'(bus.dl_done), 0);
    chk("arst_dl_overflow", 32'(bus.dl_overflow), 0);
    cyc(); cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(); mid();
      chk("post_rst_we", 32'(bus.mem_we), 0);
      chk("post_rst_done", 32'(bus.dl_done), 0);
    end

    chk("all_writes_seen", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/atom_mem_arbiter.md
Name: atom_mem_arbiter

Overview:
- Sequences the single shared 192 KB single-port Atom memory (RAM/ROM image) between two requesters: the CPU bus and the HPS utility-ROM download stream.
- The CPU always has priority. Download bytes are buffered in a small FIFO and written into the slot-7 RAM page during idle memory cycles.
- Also enforces write protection on ROM pages and holds the CPU while a download is in progress.

Parameters:
- FIFO_DEPTH, 4, download write buffer entries (power of two, ≥2).
- DL_BASE, 18'h17000, memory address of download byte 0 (slot-7 utility page).
- WP_MASK, 64'h0000_F4C0_007F_F000, one bit per 4 KB page (mem_addr[17:12]); 1 = CPU writes suppressed.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_en  in  1  CPU bus cycle requested this clock.
- cpu_addr  in  18  CPU memory address.
- cpu_we  in  1  CPU write.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  registered CPU read data.
- dl_active  in  1  download in progress (index already qualified).
- dl_wr  in  1  download byte strobe.
- dl_addr  in  12  byte offset within page.
- dl_data  in  8  download byte.
- dl_wait  out  1  backpressure to HPS (ioctl_wait).
- dl_done  out  1  one-cycle pulse when download fully committed.
- dl_overflow  out  1  sticky: a byte was dropped.
- cpu_hold  out  1  hold CPU in reset/wait.
- mem_addr  out  18  memory address.
- mem_we  out  1  memory write enable.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data (valid the cycle after the address is presented; memory registers the address).

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; state IDLE.
  - cpu_dout=0, dl_wait=0, dl_done=0, dl_overflow=0, cpu_hold=0, mem_we=0, mem_addr=0, mem_din=0.
- Grant, evaluated every cycle, combinational mux to mem_*:
  - cpu_en=1 → CPU grant:
    - mem_addr=cpu_addr, mem_din=cpu_din.
    - mem_we = cpu_we & ~WP_MASK[cpu_addr[17:12]].
  - else FIFO non-empty → LOAD grant:
    - pop head; mem_addr = DL_BASE + {6'b0, head.addr} (18-bit add, wraps mod 2^18); mem_din=head.data; mem_we=1.
    - Loader writes ignore WP_MASK.
  - else idle: mem_addr holds the last CPU address, mem_we=0.
- CPU read latency:
  - cpu_en in cycle N with cpu_we=0 → cpu_dout loads mem_dout at the edge ending cycle N+1, so it is valid from N+2.
  - cpu_dout is held until the next CPU read completes.
  - CPU writes and LOAD grants never change cpu_dout.
- FIFO:
  - Entry = {addr[11:0], data[7:0]}.
  - Push on dl_wr when not full, or when full with a pop in the same cycle (count unchanged).
  - dl_wr while full with no pop → byte dropped, dl_overflow←1. dl_overflow clears only on a dl_active rising edge.
  - dl_wait is registered: 1 when the next-cycle count ≥ FIFO_DEPTH-1, else 0.
  - Simultaneous push and pop on an empty FIFO: the entry is not bypassed; it pops no earlier than the following cycle.
- State machine:
  - IDLE → LOADING on dl_active rising edge: cpu_hold←1, dl_overflow←0.
  - LOADING → DRAIN when dl_active=0.
  - DRAIN → LOADING if dl_active rises again.
  - DRAIN → DONE when the FIFO is empty and no pop is occurring this cycle.
  - DONE (1 cycle): dl_done=1, cpu_hold←0 → IDLE.
  - cpu_hold=1 in LOADING and DRAIN.
  - CPU grants are still honoured while cpu_hold=1. Holding the CPU is the core's responsibility; the arbiter never blocks cpu_en.
- A dl_wr arriving in IDLE (no dl_active) is still queued and written; no state change.
- Reset mid-download: FIFO contents discarded and no dl_done is issued; outputs return to reset values.

Test Plan:
- CPU read: preload mem[0x0C123]=8'hA5; cpu_en=1, cpu_addr=18'h0C123, cpu_we=0 in cycle N → mem_we=0 in N; cpu_dout=8'hA5 from N+2 and held for 10 idle cycles.
- Write protection:
  - CPU write 8'h3C to 18'h0F000 → mem_we=0.
  - CPU write to 18'h02000 → mem_we=1, mem_din=8'h3C.
  - CPU write to 18'h17010 (slot 7, unprotected) → mem_we=1.
- Download with contention:
  - dl_active rises → cpu_hold=1 next cycle.
  - 4 back-to-back dl_wr (offsets 0..3, data 10..13) while cpu_en=1 continuously → no mem writes from loader; dl_wait=1 once 3 queued.
  - cpu_en drops → writes to 17000..17003 on 4 consecutive cycles, in order.
- Overflow: FIFO full, cpu_en held high, 1 extra dl_wr → dl_overflow=1 and the byte is never written; a new dl_active rising edge clears dl_overflow.
- Completion: dl_active falls with 2 entries queued → 2 LOAD writes, then dl_done single-cycle pulse with cpu_hold falling in the same cycle.
- Async reset mid-drain with 3 entries queued → all outputs 0 immediately; no further mem_we, no dl_done after reset release.
